// File: rtl/hex_word_tx_framer_if.sv
// Handshake bundle between a word producer, the hex framer and the UART TX.
// master: producer/UART side (drives the word, samples the byte stream).
// slave : framer side.
interface hex_word_tx_framer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;

    modport master (
        output word_in, word_valid, tx_ready,
        input  word_ready, tx_data, tx_valid, busy
    );

    modport slave (
        input  word_in, word_valid, tx_ready,
        output word_ready, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/hex_word_tx_framer.sv
// Converts a binary word into uppercase ASCII hex characters (MS nibble
// first), optionally followed by CR/LF, and streams them one byte at a time
// over a valid/ready link to the UART transmitter. All outputs are registered.
module hex_word_tx_framer #(
    parameter int DATA_WIDTH = 16,
    parameter bit SEND_CRLF  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_word_tx_framer_if.slave  bus
);
    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Reject widths that do not split evenly into nibbles.
    generate
        if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_bad_width
            $error("hex_word_tx_framer: DATA_WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] word_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  word_ready_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib_at(input logic [DATA_WIDTH-1:0] w,
                                          input logic [CW-1:0] i);
        logic [DATA_WIDTH-1:0] s;
        s = w >> {i, 2'b00};
        return s[3:0];
    endfunction

    wire xfer = tx_valid_q && bus.tx_ready;

    // Frame sequencer: accepts a word in IDLE, then walks the nibbles down
    // to zero, then the optional CR/LF trailer; each step waits for a transfer
    // so the presented byte is held stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            word_q       <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            word_ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.word_valid) begin
                        word_q       <= bus.word_in;
                        cnt          <= CW'(NIBBLES - 1);
                        tx_data_q    <= hex_ascii(bus.word_in[DATA_WIDTH-1 -: 4]);
                        tx_valid_q   <= 1'b1;
                        word_ready_q <= 1'b0;
                        state        <= HEX;
                    end
                end
                HEX: begin
                    if (xfer) begin
                        if (cnt != '0) begin
                            cnt       <= cnt - CW'(1);
                            tx_data_q <= hex_ascii(nib_at(word_q, cnt - CW'(1)));
                        end else if (SEND_CRLF) begin
                            tx_data_q <= 8'h0D;
                            state     <= CR;
                        end else begin
                            tx_valid_q   <= 1'b0;
                            word_ready_q <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (xfer) begin
                        tx_data_q <= 8'h0A;
                        state     <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        tx_valid_q   <= 1'b0;
                        word_ready_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    tx_valid_q   <= 1'b0;
                    word_ready_q <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.word_ready = word_ready_q;
    assign bus.busy       = ~word_ready_q;
endmodule

// File: tb/tb_hex_word_tx_framer.sv
// Bench for hex_word_tx_framer: a 16-bit/CRLF instance and an 8-bit/no-CRLF
// instance, randomized tx_ready, and a string-based model of the byte stream.
module tb_hex_word_tx_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tx_ready;
    bit   sel;          // 0: 16-bit instance observed, 1: 8-bit instance
    int   n_cmp = 0;
    int   n_bad = 0;

    hex_word_tx_framer_if #(.DATA_WIDTH(16)) if16 ();
    hex_word_tx_framer_if #(.DATA_WIDTH(8))  if8 ();

    assign if16.tx_ready = tx_ready;
    assign if8.tx_ready  = tx_ready;

    hex_word_tx_framer #(.DATA_WIDTH(16), .SEND_CRLF(1'b1)) dut16 (
        .clk(clk), .rst(rst), .bus(if16));
    hex_word_tx_framer #(.DATA_WIDTH(8), .SEND_CRLF(1'b0)) dut8 (
        .clk(clk), .rst(rst), .bus(if8));

    wire       o_valid = sel ? if8.tx_valid   : if16.tx_valid;
    wire [7:0] o_data  = sel ? if8.tx_data    : if16.tx_data;
    wire       o_ready = sel ? if8.word_ready : if16.word_ready;
    wire       o_busy  = sel ? if8.busy       : if16.busy;

    // Expected byte stream, as "hh hh ... " text.
    function automatic string model(input logic [15:0] w, input int nib, input bit crlf);
        string hx = "0123456789ABCDEF";
        string s  = "";
        int    d;
        for (int i = nib - 1; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 16'hF);
            s = {s, $sformatf("%02h ", hx[d])};
        end
        if (crlf) s = {s, "0d 0a "};
        return s;
    endfunction

    // Observe one frame from the sample just after acceptance until word_ready.
    task automatic collect(input int pct, output string got, output bit lat_ok,
                           output int hold_err, output int busy_err,
                           output int ncyc, output bit tmo);
        bit pv = 0, pr = 0;
        logic [7:0] pd = 8'h00;
        bit done = 0;
        got = ""; hold_err = 0; busy_err = 0; ncyc = 0;
        lat_ok = o_valid && !o_ready;
        for (int k = 0; k < 300 && !done; k++) begin
            if (o_ready) begin
                done = 1;
            end else begin
                if (o_busy !== ~o_ready) busy_err++;
                if (pv && !pr && (o_valid !== 1'b1 || o_data !== pd)) hold_err++;
                tx_ready = ($urandom_range(99) < pct);
                if (o_valid && tx_ready) got = {got, $sformatf("%02h ", o_data)};
                pv = o_valid; pr = tx_ready; pd = o_data; ncyc++;
                @(posedge clk); #1;
            end
        end
        tmo = !done;
    endtask

    // Present a word to the selected instance (which must be idle) and collect the frame.
    task automatic run(input logic [15:0] w, input int pct, output string got,
                       output bit lat_ok, output int hold_err, output int busy_err,
                       output int ncyc, output bit tmo);
        if (sel) begin if8.word_in = w[7:0]; if8.word_valid = 1'b1; end
        else     begin if16.word_in = w;     if16.word_valid = 1'b1; end
        @(posedge clk); #1;
        if8.word_valid  = 1'b0;
        if16.word_valid = 1'b0;
        if (sel) if8.word_in = 8'($urandom); else if16.word_in = 16'($urandom);
        collect(pct, got, lat_ok, hold_err, busy_err, ncyc, tmo);
    endtask

    task automatic test_reset();
        n_cmp++; if (if16.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid16 got=%b exp=0", if16.tx_valid); end
        n_cmp++; if (if16.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data16 got=%h exp=00", if16.tx_data); end
        n_cmp++; if (if16.word_ready !== 1'b1) begin n_bad++; $display("FAIL reset_word_ready16 got=%b exp=1", if16.word_ready); end
        n_cmp++; if (if16.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy16 got=%b exp=0", if16.busy); end
        n_cmp++; if (if8.tx_valid !== 1'b0 || if8.word_ready !== 1'b1) begin n_bad++; $display("FAIL reset_8 got valid=%b ready=%b exp valid=0 ready=1", if8.tx_valid, if8.word_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (if16.tx_valid !== 1'b0 || if16.word_ready !== 1'b1) begin n_bad++; $display("FAIL idle_after_reset got valid=%b ready=%b exp valid=0 ready=1", if16.tx_valid, if16.word_ready); end
    endtask

    task automatic test_basic();
        string got; bit lat, tmo; int he, be, nc;
        sel = 0;
        run(16'h1A3F, 100, got, lat, he, be, nc, tmo);
        n_cmp++; if (got != model(16'h1A3F, 4, 1)) begin n_bad++; $display("FAIL basic_bytes got=%s exp=%s", got, model(16'h1A3F, 4, 1)); end
        n_cmp++; if (!lat) begin n_bad++; $display("FAIL basic_latency got=0 exp=1"); end
        n_cmp++; if (nc != 6 || tmo) begin n_bad++; $display("FAIL basic_cycles got=%0d tmo=%b exp=6", nc, tmo); end
        n_cmp++; if (be != 0) begin n_bad++; $display("FAIL basic_busy got=%0d errs exp=0", be); end
    endtask

    task automatic test_backpressure();
        string got; bit lat, tmo; int he, be, nc;
        sel = 0;
        for (int r = 0; r < 3; r++) begin
            run(16'hBEEF, 50, got, lat, he, be, nc, tmo);
            n_cmp++; if (got != model(16'hBEEF, 4, 1) || tmo) begin n_bad++; $display("FAIL bp_bytes got=%s exp=%s tmo=%b", got, model(16'hBEEF, 4, 1), tmo); end
            n_cmp++; if (he != 0) begin n_bad++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", he); end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] words [6] = '{16'h0000, 16'hFFFF, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        string got; bit lat, tmo; int he, be, nc;
        sel = 0;
        foreach (words[i]) begin
            run(words[i], 70, got, lat, he, be, nc, tmo);
            n_cmp++; if (got != model(words[i], 4, 1) || tmo || he != 0) begin n_bad++; $display("FAIL extreme_%h got=%s exp=%s hold=%0d", words[i], got, model(words[i], 4, 1), he); end
        end
    endtask

    task automatic test_random();
        string got; bit lat, tmo; int he, be, nc;
        logic [15:0] w;
        sel = 0;
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            run(w, 60, got, lat, he, be, nc, tmo);
            n_cmp++; if (got != model(w, 4, 1) || tmo || he != 0 || be != 0 || !lat) begin n_bad++; $display("FAIL random_%h got=%s exp=%s hold=%0d busy=%0d lat=%b", w, got, model(w, 4, 1), he, be, lat); end
        end
    endtask

    task automatic test_handshake();
        string got; bit lat, tmo; int he, be, nc;
        logic [15:0] a;
        sel = 0;
        a = 16'h5A00 | 16'($urandom_range(255));
        if16.word_in = a; if16.word_valid = 1'b1;
        @(posedge clk); #1;
        // word_valid stays high with a new word during the whole frame
        if16.word_in = 16'h1234;
        collect(100, got, lat, he, be, nc, tmo);
        n_cmp++; if (got != model(a, 4, 1) || nc != 6 || tmo) begin n_bad++; $display("FAIL hs_first got=%s cyc=%0d exp=%s cyc=6", got, nc, model(a, 4, 1)); end
        // this is the single IDLE cycle: the held word is taken at the next edge
        @(posedge clk); #1;
        if16.word_valid = 1'b0;
        if16.word_in = 16'($urandom);
        collect(100, got, lat, he, be, nc, tmo);
        n_cmp++; if (got != model(16'h1234, 4, 1) || !lat || tmo) begin n_bad++; $display("FAIL hs_held got=%s lat=%b exp=%s lat=1", got, lat, model(16'h1234, 4, 1)); end
    endtask

    task automatic test_reset_mid();
        string got, part; bit lat, tmo; int he, be, nc;
        sel = 0; part = "";
        if16.word_in = 16'hCAFE; if16.word_valid = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        if16.word_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (o_valid) part = {part, $sformatf("%02h ", o_data)};
            @(posedge clk); #1;
        end
        n_cmp++; if (part != "43 41 ") begin n_bad++; $display("FAIL rstmid_prefix got=%s exp=43 41 ", part); end
        rst = 1'b1; if16.word_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if16.word_valid = 1'b0;
        n_cmp++; if (if16.tx_valid !== 1'b0 || if16.word_ready !== 1'b1 || if16.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_abandon got valid=%b ready=%b busy=%b exp 0 1 0", if16.tx_valid, if16.word_ready, if16.busy); end
        run(16'h00FF, 100, got, lat, he, be, nc, tmo);
        n_cmp++; if (got != model(16'h00FF, 4, 1) || nc != 6 || tmo) begin n_bad++; $display("FAIL rstmid_next got=%s cyc=%0d exp=%s cyc=6", got, nc, model(16'h00FF, 4, 1)); end
    endtask

    task automatic test_w8();
        string got; bit lat, tmo; int he, be, nc;
        logic [7:0] w;
        sel = 1;
        for (int i = 0; i < 2; i++) begin
            run(16'h009C, 100, got, lat, he, be, nc, tmo);
            n_cmp++; if (got != model(16'h009C, 2, 0) || nc != 2 || !lat || tmo) begin n_bad++; $display("FAIL w8_9c_%0d got=%s cyc=%0d lat=%b exp=%s cyc=2 lat=1", i, got, nc, lat, model(16'h009C, 2, 0)); end
        end
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            run({8'h00, w}, 50, got, lat, he, be, nc, tmo);
            n_cmp++; if (got != model({8'h00, w}, 2, 0) || he != 0 || tmo) begin n_bad++; $display("FAIL w8_rand_%h got=%s exp=%s hold=%0d", w, got, model({8'h00, w}, 2, 0), he); end
        end
        sel = 0;
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b0; sel = 0;
        if16.word_in = '0; if16.word_valid = 1'b0;
        if8.word_in  = '0; if8.word_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_extremes();
        test_random();
        test_handshake();
        test_reset_mid();
        test_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_word_tx_framer.md
Name: hex_word_tx_framer

Overview:
- Accepts a binary data word from an upstream producer (e.g. a sensor sample or PID term) through a valid/ready handshake.
- Converts the word, nibble by nibble, into uppercase ASCII hex characters, optionally followed by CR/LF.
- Streams the characters one byte at a time to the UART transmitter through a second valid/ready handshake.
- Sits between the control datapath and the UART TX, and owns sequencing and backpressure for the debug telemetry link.

Parameters:
- DATA_WIDTH, 16, width of input word. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- SEND_CRLF, 1, when 1, append 0x0D then 0x0A after the hex digits; when 0, send hex digits only.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- word_in  input  DATA_WIDTH  binary word to transmit; sampled only on acceptance.
- word_valid  input  1  upstream word available.
- word_ready  output  1  framer can accept a word (high only in IDLE).
- tx_data  output  8  ASCII byte to UART TX.
- tx_valid  output  1  tx_data holds a valid byte.
- tx_ready  input  1  UART TX accepts a byte.
- busy  output  1  frame in progress; equals NOT word_ready.

Behaviour:
- Reset values: tx_valid=0, tx_data=0x00, word_ready=1, busy=0, state=IDLE, nibble counter=0. Reset overrides every other input in the same cycle.
- Nibble-to-ASCII mapping: 0x0-0x9 map to 0x30-0x39; 0xA-0xF map to 0x41-0x46 (uppercase only).
- NIBBLES = DATA_WIDTH/4. Digits are sent most-significant nibble first.
- State IDLE:
  - word_ready=1, tx_valid=0.
  - When word_valid=1 at a rising edge, the word is accepted: latch word_in, set the counter to NIBBLES-1, go to HEX.
  - From the next cycle: tx_valid=1, tx_data=ASCII of the top nibble, word_ready=0.
- State HEX:
  - A byte transfer occurs at an edge with tx_valid=1 and tx_ready=1.
  - On a transfer with counter>0: decrement the counter; present the next nibble's ASCII in the following cycle.
  - On a transfer with counter=0: go to CR if SEND_CRLF=1, otherwise go to IDLE.
- State CR: tx_data=0x0D; on transfer go to LF.
- State LF: tx_data=0x0A; on transfer go to IDLE.
- Returning to IDLE: tx_valid=0 and word_ready=1 in the cycle after the final transfer.
- Outputs are registered. tx_data and tx_valid change only on an edge.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable; a byte is never dropped or withdrawn.
- Throughput: with tx_ready held high, one byte per cycle. A frame is NIBBLES+2 bytes (SEND_CRLF=1) or NIBBLES bytes, followed by exactly one IDLE cycle before the next word is accepted.
- Latency: the first byte is valid on the cycle after word acceptance.
- word_valid while busy: ignored. The upstream producer must hold the word until it sees word_ready. word_in changes after acceptance have no effect on the frame in flight.
- tx_ready while tx_valid=0: no effect.
- Reset mid-frame: the frame is abandoned. The next cycle shows tx_valid=0 and word_ready=1. There is no partial resume and no trailing CR/LF.
- The nibble counter is ceil(log2(NIBBLES)) bits wide, minimum 1 bit, and never wraps below 0.

Test Plan:
1. DATA_WIDTH=16, SEND_CRLF=1, tx_ready=1, word 0x1A3F -> bytes 0x31,0x41,0x33,0x46,0x0D,0x0A on 6 consecutive cycles starting the cycle after acceptance; word_ready=1 the cycle after 0x0A.
2. Backpressure: word 0xBEEF, tx_ready pseudo-random (~50%) -> byte sequence 0x42,0x45,0x45,0x46,0x0D,0x0A; tx_data constant during every tx_valid=1 and tx_ready=0 cycle; no duplicated or missing bytes.
3. Extremes: 0x0000 -> 0x30 x4 then CR/LF; 0xFFFF -> 0x46 x4 then CR/LF; check every digit 0-F once via 0x0123, 0x4567, 0x89AB, 0xCDEF.
4. Handshake: present 0x1234 with word_valid held high during an active frame -> not accepted until the IDLE cycle; then sent as 0x31,0x32,0x33,0x34,0x0D,0x0A. Changing word_in mid-frame leaves the in-flight frame unaltered.
5. Reset after 2 bytes of 0xCAFE -> next cycle tx_valid=0 and word_ready=1; a following word 0x00FF is emitted completely (0x30,0x30,0x46,0x46,0x0D,0x0A).
6. DATA_WIDTH=8, SEND_CRLF=0, word 0x9C -> exactly 0x39,0x43, then IDLE; back-to-back words 0x9C, 0x9C -> one IDLE cycle between frames.
